// File: rtl/div_pkg.sv
// div_pkg: shared constants, width helper and parameter range check for the divisibility detector
`define DIV_CHECK_PARAMS(n, w) \
  if ((n) < div_pkg::N_MIN || (n) > div_pkg::N_MAX || (w) < 1 || (w) > div_pkg::W_MAX) begin : g_bad_params \
    $error("div_by_n_detector: N or W outside legal range"); \
  end

package div_pkg;
  localparam int N_MIN = 2;
  localparam int N_MAX = 65535;
  localparam int W_MAX = 8;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/div_by_n_detector_mod_shift_step.sv
// mod_shift_step: one MSB-first remainder step, (2*r_in + bit_in) mod N via a single conditional subtract
module mod_shift_step #(
  parameter int N  = 3,
  parameter int RW = 2
) (
  input  logic [RW-1:0] r_in,
  input  logic          bit_in,
  output logic [RW-1:0] r_out
);
  logic [RW:0] t;
  always_comb begin
    t = {r_in, bit_in};
    r_out = (t >= (RW+1)'(N)) ? RW'(t - (RW+1)'(N)) : RW'(t);
  end
endmodule

// File: rtl/div_by_n_detector.sv
// div_by_n_detector: streaming MSB-first divisibility test of an unsigned number against modulus N
module div_by_n_detector
  import div_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 1,
  parameter int LW = 8,
  localparam int RW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          start,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  output logic          divisible,
  output logic [RW-1:0] remainder,
  output logic [LW-1:0] len
);
  `DIV_CHECK_PARAMS(N, W)
  logic [RW-1:0] rem_q, rem_d;
  logic [LW-1:0] len_q, len_d;
  logic          div_q, div_d, ov_q, ov_d;
  logic [W:0][RW-1:0] chain;
  assign chain[0] = start ? '0 : rem_q;
  for (genvar i = 0; i < W; i++) begin : g_step
    mod_shift_step #(.N(N), .RW(RW)) u_step (
      .r_in  (chain[i]),
      .bit_in(x[W-1-i]),
      .r_out (chain[i+1])
    );
  end
  // an idle start clears the number without reporting it divisible
  always_comb begin
    rem_d = in_valid ? chain[W] : start ? '0 : rem_q;
    len_d = in_valid ? (start ? LW'(1) : (&len_q ? len_q : len_q + LW'(1))) : start ? '0 : len_q;
    div_d = in_valid ? (chain[W] == '0) : start ? 1'b0 : div_q;
    ov_d  = in_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      len_q <= '0;
      div_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      len_q <= len_d;
      div_q <= div_d;
      ov_q  <= ov_d;
    end
  end
  assign remainder = rem_q;
  assign len       = len_q;
  assign divisible = div_q;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_div_by_n_detector.sv
// tb_div_by_n_detector: several detector configurations on one shared stream, checked against an arithmetic model
module tb_div_by_n_detector;
  localparam int ND = 7;
  localparam int NS [ND] = '{3, 5, 7, 65535, 2, 10, 255};
  localparam int WS [ND] = '{1, 4, 2, 8, 3, 4, 8};
  localparam int LS [ND] = '{8, 8, 8, 4, 8, 8, 8};
  logic clk = 1'b0;
  logic reset, in_valid, start;
  logic [7:0] x8;
  logic [ND-1:0][31:0] rem_a, len_a;
  logic [ND-1:0] div_a, ov_a;
  int m_r [ND], m_l [ND];
  bit m_d [ND], m_o [ND];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [$clog2(NS[g])-1:0] rw;
    logic [LS[g]-1:0] lw;
    logic dv, ov;
    div_by_n_detector #(.N(NS[g]), .W(WS[g]), .LW(LS[g])) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .start    (start),
      .x        (x8[WS[g]-1:0]),
      .out_valid(ov),
      .divisible(dv),
      .remainder(rw),
      .len      (lw)
    );
    assign rem_a[g] = 32'(rw);
    assign len_a[g] = 32'(lw);
    assign div_a[g] = dv;
    assign ov_a[g]  = ov;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] xv);
    reset = r; in_valid = v; start = s; x8 = xv;
    @(posedge clk);
    for (int i = 0; i < ND; i++) begin
      if (r) begin
        m_r[i] = 0; m_l[i] = 0; m_d[i] = 0; m_o[i] = 0;
      end else if (v) begin
        m_r[i] = ((s ? 0 : m_r[i]) * (1 << WS[i]) + int'(xv & 8'((1 << WS[i]) - 1))) % NS[i];
        m_l[i] = s ? 1 : (m_l[i] < (1 << LS[i]) - 1 ? m_l[i] + 1 : m_l[i]);
        m_d[i] = (m_r[i] == 0);
        m_o[i] = 1;
      end else if (s) begin
        m_r[i] = 0; m_l[i] = 0; m_d[i] = 0; m_o[i] = 0;
      end else m_o[i] = 0;
    end
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("model_rem[N=%0d]", NS[i]), int'(rem_a[i]), m_r[i]);
      chk($sformatf("model_len[N=%0d]", NS[i]), int'(len_a[i]), m_l[i]);
      chk($sformatf("model_div[N=%0d]", NS[i]), int'(div_a[i]), int'(m_d[i]));
      chk($sformatf("model_ov[N=%0d]", NS[i]), int'(ov_a[i]), int'(m_o[i]));
    end
  endtask
  initial begin
    step(1, 0, 0, 8'h00);
    chk("reset_rem", int'(rem_a[0]), 0);
    chk("reset_len", int'(len_a[0]), 0);
    chk("reset_div", int'(div_a[0]), 0);
    chk("reset_ov", int'(ov_a[0]), 0);
    step(0, 1, 1, 8'h01); chk("t1_rem1", int'(rem_a[0]), 1); chk("t1_div1", int'(div_a[0]), 0); chk("t1_len1", int'(len_a[0]), 1); chk("t1_ov1", int'(ov_a[0]), 1);
    step(0, 1, 0, 8'h01); chk("t1_rem2", int'(rem_a[0]), 0); chk("t1_div2", int'(div_a[0]), 1); chk("t1_len2", int'(len_a[0]), 2); chk("t1_ov2", int'(ov_a[0]), 1);
    step(0, 1, 0, 8'h00); chk("t1_rem3", int'(rem_a[0]), 0); chk("t1_div3", int'(div_a[0]), 1); chk("t1_len3", int'(len_a[0]), 3); chk("t1_ov3", int'(ov_a[0]), 1);
    step(0, 1, 1, 8'h01); chk("t2_rem1", int'(rem_a[1]), 1); chk("t2_div1", int'(div_a[1]), 0);
    step(0, 1, 0, 8'h09); chk("t2_rem2", int'(rem_a[1]), 0); chk("t2_div2", int'(div_a[1]), 1);
    step(0, 1, 0, 8'h03); chk("t2_rem3", int'(rem_a[1]), 3); chk("t2_div3", int'(div_a[1]), 0);
    step(0, 1, 1, 8'h03); chk("t3_rem1", int'(rem_a[2]), 3); chk("t3_len1", int'(len_a[2]), 1);
    step(0, 0, 0, 8'hxx); chk("t3_gap1_rem", int'(rem_a[2]), 3); chk("t3_gap1_ov", int'(ov_a[2]), 0); chk("t3_gap1_len", int'(len_a[2]), 1);
    step(0, 0, 0, 8'hxx); chk("t3_gap2_rem", int'(rem_a[2]), 3); chk("t3_gap2_ov", int'(ov_a[2]), 0); chk("t3_gap2_len", int'(len_a[2]), 1);
    step(0, 1, 0, 8'h01); chk("t3_rem2", int'(rem_a[2]), 6); chk("t3_len2", int'(len_a[2]), 2); chk("t3_ov2", int'(ov_a[2]), 1);
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h00); chk("t4_pre_rem", int'(rem_a[0]), 2);
    step(0, 1, 1, 8'h00); chk("t4_rem", int'(rem_a[0]), 0); chk("t4_div", int'(div_a[0]), 1); chk("t4_len", int'(len_a[0]), 1);
    step(0, 0, 1, 8'h00); chk("t4_idle_rem", int'(rem_a[0]), 0); chk("t4_idle_div", int'(div_a[0]), 0); chk("t4_idle_len", int'(len_a[0]), 0);
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h01);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00); chk("t5_pre_rem", int'(rem_a[0]), 2); chk("t5_pre_len", int'(len_a[0]), 5);
    step(1, 1, 0, 8'h01); chk("t5_rem", int'(rem_a[0]), 0); chk("t5_len", int'(len_a[0]), 0); chk("t5_div", int'(div_a[0]), 0); chk("t5_ov", int'(ov_a[0]), 0);
    step(0, 1, 0, 8'h01); chk("t5_after_rem", int'(rem_a[0]), 1); chk("t5_after_len", int'(len_a[0]), 1);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, k == 1, 8'hFF);
      chk($sformatf("t6_rem%0d", k), int'(rem_a[3]), (k % 2) ? 255 : 0);
      chk($sformatf("t6_len%0d", k), int'(len_a[3]), k < 15 ? k : 15);
    end
    for (int k = 0; k < 400; k++)
      step($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(7) == 0, 8'($urandom));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
